// File: rtl/cache_req_arbiter_pkg.sv
// rtl/cache_req_arbiter_pkg.sv - shared types for the cache request arbiter
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } owner_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Round-robin hand-off: the port that was just served yields priority
  function automatic owner_e other_owner(input owner_e o);
    return (o == M0) ? M1 : M0;
  endfunction

endpackage

// File: rtl/cache_req_arbiter_if.sv
// rtl/cache_req_arbiter_if.sv - requester and cache-side signal bundle
interface cache_req_arbiter_if;
  logic        m0_req_i;
  logic        m0_we_i;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_wdata_i;
  logic [31:0] m0_rdata_o;
  logic        m0_ack_o;
  logic        m0_err_o;

  logic        m1_req_i;
  logic        m1_we_i;
  logic [31:0] m1_addr_i;
  logic [31:0] m1_wdata_i;
  logic [31:0] m1_rdata_o;
  logic        m1_ack_o;
  logic        m1_err_o;

  logic        c_read_o;
  logic        c_write_o;
  logic [31:0] c_addr_o;
  logic [31:0] c_data_o;
  logic [31:0] c_data_i;
  logic        c_valid_i;

  // Arbiter side
  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    output m0_rdata_o, m0_ack_o, m0_err_o,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    output m1_rdata_o, m1_ack_o, m1_err_o,
    output c_read_o, c_write_o, c_addr_o, c_data_o,
    input  c_data_i, c_valid_i
  );

  // Environment side: both requesters plus the cache
  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i,
    input  m0_rdata_o, m0_ack_o, m0_err_o,
    output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
    input  m1_rdata_o, m1_ack_o, m1_err_o,
    input  c_read_o, c_write_o, c_addr_o, c_data_o,
    output c_data_i, c_valid_i
  );
endinterface

// File: rtl/cache_req_arbiter_rr.sv
// rtl/cache_req_arbiter_rr.sv - two-way round-robin pick with priority pointer
module rr_arbiter2
  import cache_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst_i,
  input  logic   req0,
  input  logic   req1,
  input  logic   update,
  input  owner_e served,
  output owner_e pick
);

  owner_e ptr;

  // Pointer moves away from the port that just completed
  always_ff @(posedge clk) begin
    if (rst_i) begin
      ptr <= M0;
    end else if (update) begin
      ptr <= other_owner(served);
    end
  end

  // A lone requester always wins; contention goes to the pointer
  always_comb begin
    pick = M0;
    if (req0 && req1) begin
      pick = ptr;
    end else if (req1) begin
      pick = M1;
    end
  end

endmodule

// File: rtl/cache_req_arbiter.sv
// rtl/cache_req_arbiter.sv - merges two requesters onto one cache port with timeout
module cache_req_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst_i,
  cache_req_arbiter_if.slave bus
);

  // One spare bit keeps the counter legal when the timeout is disabled
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_e  state;
  owner_e      owner;
  owner_e      pick;
  req_t        cur;
  req_t        sel;
  logic [CW-1:0] cnt;

  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic        c_read, c_write;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst_i  (rst_i),
    .req0   (bus.m0_req_i),
    .req1   (bus.m1_req_i),
    .update (state == DONE),
    .served (owner),
    .pick   (pick)
  );

  // Request fields of whichever port the round-robin picked
  always_comb begin
    sel = '0;
    if (pick == M1) begin
      sel = '{we: bus.m1_we_i, addr: bus.m1_addr_i, wdata: bus.m1_wdata_i};
    end else begin
      sel = '{we: bus.m0_we_i, addr: bus.m0_addr_i, wdata: bus.m0_wdata_i};
    end
  end

  // Main transaction FSM; every output is a register
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state    <= IDLE;
      owner    <= M0;
      cur      <= '0;
      cnt      <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m1_err   <= 1'b0;
      c_read   <= 1'b0;
      c_write  <= 1'b0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.m0_req_i || bus.m1_req_i) begin
            owner   <= pick;
            cur     <= sel;
            c_read  <= !sel.we;
            c_write <= sel.we;
            cnt     <= CW'(1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (bus.c_valid_i) begin
            c_read  <= 1'b0;
            c_write <= 1'b0;
            if (owner == M1) begin
              m1_ack <= 1'b1;
              if (!cur.we) m1_rdata <= bus.c_data_i;
            end else begin
              m0_ack <= 1'b1;
              if (!cur.we) m0_rdata <= bus.c_data_i;
            end
            state <= DONE;
          end else if ((TIMEOUT != 0) && (cnt == CW'(TIMEOUT))) begin
            c_read  <= 1'b0;
            c_write <= 1'b0;
            if (owner == M1) begin
              m1_err   <= 1'b1;
              m1_rdata <= '0;
            end else begin
              m0_err   <= 1'b1;
              m0_rdata <= '0;
            end
            state <= DONE;
          end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.m0_rdata_o = m0_rdata;
  assign bus.m1_rdata_o = m1_rdata;
  assign bus.m0_ack_o   = m0_ack;
  assign bus.m1_ack_o   = m1_ack;
  assign bus.m0_err_o   = m0_err;
  assign bus.m1_err_o   = m1_err;
  assign bus.c_read_o   = c_read;
  assign bus.c_write_o  = c_write;
  assign bus.c_addr_o   = cur.addr;
  assign bus.c_data_o   = cur.wdata;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// tb/tb_cache_req_arbiter.sv - directed self-checking bench for cache_req_arbiter
module tb_cache_req_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_req_arbiter_if a ();
  cache_req_arbiter_if b ();

  cache_req_arbiter #(.TIMEOUT(4)) dut_a (
    .clk   (clk),
    .rst_i (rst),
    .bus   (a.slave)
  );

  cache_req_arbiter #(.TIMEOUT(0)) dut_b (
    .clk   (clk),
    .rst_i (rst),
    .bus   (b.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    a.m0_req_i = 0; a.m0_we_i = 0; a.m0_addr_i = 0; a.m0_wdata_i = 0;
    a.m1_req_i = 0; a.m1_we_i = 0; a.m1_addr_i = 0; a.m1_wdata_i = 0;
    a.c_data_i = 0; a.c_valid_i = 0;
    b.m0_req_i = 0; b.m0_we_i = 0; b.m0_addr_i = 0; b.m0_wdata_i = 0;
    b.m1_req_i = 0; b.m1_we_i = 0; b.m1_addr_i = 0; b.m1_wdata_i = 0;
    b.c_data_i = 0; b.c_valid_i = 0;

    // reset state
    rst = 1'b1;
    repeat (2) tick();
    check("rst c_read", a.c_read_o, 0);
    check("rst c_write", a.c_write_o, 0);
    check("rst m0_ack", a.m0_ack_o, 0);
    check("rst m0_rdata", a.m0_rdata_o, 0);
    rst = 1'b0;

    // m0 read 0x100, valid in cycle 3
    a.m0_req_i = 1; a.m0_we_i = 0; a.m0_addr_i = 32'h100;
    tick();
    check("t1 c1 c_read", a.c_read_o, 1);
    check("t1 c1 c_write", a.c_write_o, 0);
    check("t1 c1 c_addr", a.c_addr_o, 32'h100);
    tick();
    check("t1 c2 c_read", a.c_read_o, 1);
    tick();
    check("t1 c3 c_read", a.c_read_o, 1);
    check("t1 c3 m0_ack", a.m0_ack_o, 0);
    a.c_valid_i = 1; a.c_data_i = 32'hDEADBEEF;
    tick();
    check("t1 c4 c_read", a.c_read_o, 0);
    check("t1 c4 m0_ack", a.m0_ack_o, 1);
    check("t1 c4 m0_rdata", a.m0_rdata_o, 32'hDEADBEEF);
    check("t1 c4 m1_ack", a.m1_ack_o, 0);
    check("t1 c4 m1_err", a.m1_err_o, 0);
    check("t1 c4 m1_rdata", a.m1_rdata_o, 0);
    a.c_valid_i = 0; a.m0_req_i = 0;
    tick();
    check("t1 c5 m0_ack", a.m0_ack_o, 0);

    // simultaneous pair after reset: m0 write first, then m1 read
    rst = 1'b1; tick(); rst = 1'b0;
    check("t2 rst m0_rdata", a.m0_rdata_o, 0);
    a.m0_req_i = 1; a.m0_we_i = 1; a.m0_addr_i = 32'h10; a.m0_wdata_i = 32'h11;
    a.m1_req_i = 1; a.m1_we_i = 0; a.m1_addr_i = 32'h20;
    tick();
    check("t2 c1 c_write", a.c_write_o, 1);
    check("t2 c1 c_read", a.c_read_o, 0);
    check("t2 c1 c_addr", a.c_addr_o, 32'h10);
    check("t2 c1 c_data", a.c_data_o, 32'h11);
    a.c_valid_i = 1; a.c_data_i = 32'h1234;
    tick();
    check("t2 c2 m0_ack", a.m0_ack_o, 1);
    check("t2 c2 m1_ack", a.m1_ack_o, 0);
    check("t2 c2 m0_rdata", a.m0_rdata_o, 0);
    a.c_valid_i = 0; a.m0_req_i = 0;
    tick();
    check("t2 c3 idle c_read", a.c_read_o, 0);
    check("t2 c3 idle c_write", a.c_write_o, 0);
    tick();
    check("t2 c4 c_read", a.c_read_o, 1);
    check("t2 c4 c_addr", a.c_addr_o, 32'h20);
    a.c_valid_i = 1; a.c_data_i = 32'hCAFE0001;
    tick();
    check("t2 c5 m1_ack", a.m1_ack_o, 1);
    check("t2 c5 m0_ack", a.m0_ack_o, 0);
    check("t2 c5 m1_rdata", a.m1_rdata_o, 32'hCAFE0001);
    a.c_valid_i = 0; a.m1_req_i = 0;
    tick();

    // lone m0 read, then pointer favours m1
    a.m0_req_i = 1; a.m0_we_i = 0; a.m0_addr_i = 32'h30;
    tick();
    check("t2b c_read", a.c_read_o, 1);
    a.c_valid_i = 1; a.c_data_i = 32'h0000A5A5;
    tick();
    check("t2b m0_ack", a.m0_ack_o, 1);
    check("t2b m0_rdata", a.m0_rdata_o, 32'h0000A5A5);
    a.c_valid_i = 0; a.m0_req_i = 0;
    tick();

    // second pair: m1 write first, then m0 read
    a.m0_req_i = 1; a.m0_we_i = 0; a.m0_addr_i = 32'h50;
    a.m1_req_i = 1; a.m1_we_i = 1; a.m1_addr_i = 32'h60; a.m1_wdata_i = 32'h61;
    tick();
    check("t2c c1 c_write", a.c_write_o, 1);
    check("t2c c1 c_read", a.c_read_o, 0);
    check("t2c c1 c_addr", a.c_addr_o, 32'h60);
    check("t2c c1 c_data", a.c_data_o, 32'h61);
    a.c_valid_i = 1; a.c_data_i = 32'h9999;
    tick();
    check("t2c c2 m1_ack", a.m1_ack_o, 1);
    check("t2c c2 m0_ack", a.m0_ack_o, 0);
    check("t2c c2 m1_rdata", a.m1_rdata_o, 32'hCAFE0001);
    a.c_valid_i = 0; a.m1_req_i = 0;
    tick();
    tick();
    check("t2c c4 c_read", a.c_read_o, 1);
    check("t2c c4 c_addr", a.c_addr_o, 32'h50);
    a.c_valid_i = 1; a.c_data_i = 32'h0000B0B0;
    tick();
    check("t2c c5 m0_ack", a.m0_ack_o, 1);
    check("t2c c5 m0_rdata", a.m0_rdata_o, 32'h0000B0B0);
    a.c_valid_i = 0; a.m0_req_i = 0;
    tick();

    // TIMEOUT=4, cache silent: strobe cycles 1..4, err in cycle 5
    a.m1_req_i = 1; a.m1_we_i = 0; a.m1_addr_i = 32'h40;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("t3 c%0d c_read", c), a.c_read_o, 1);
      check($sformatf("t3 c%0d m1_err", c), a.m1_err_o, 0);
    end
    tick();
    check("t3 c5 c_read", a.c_read_o, 0);
    check("t3 c5 m1_err", a.m1_err_o, 1);
    check("t3 c5 m1_ack", a.m1_ack_o, 0);
    check("t3 c5 m0_err", a.m0_err_o, 0);
    check("t3 c5 m1_rdata", a.m1_rdata_o, 0);
    a.m1_req_i = 0;
    tick();
    check("t3 c6 m1_err", a.m1_err_o, 0);

    // TIMEOUT=4, valid in cycle 4 wins
    a.m1_req_i = 1; a.m1_we_i = 0; a.m1_addr_i = 32'h44;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("t3b c%0d c_read", c), a.c_read_o, 1);
    end
    a.c_valid_i = 1; a.c_data_i = 32'h55;
    tick();
    check("t3b c5 m1_ack", a.m1_ack_o, 1);
    check("t3b c5 m1_err", a.m1_err_o, 0);
    check("t3b c5 m1_rdata", a.m1_rdata_o, 32'h55);
    a.c_valid_i = 0; a.m1_req_i = 0;
    tick();

    // m0 write so the pointer favours m1 before the reset test
    a.m0_req_i = 1; a.m0_we_i = 1; a.m0_addr_i = 32'h70; a.m0_wdata_i = 32'h71;
    tick();
    check("t4a c_write", a.c_write_o, 1);
    a.c_valid_i = 1; a.c_data_i = 32'h0;
    tick();
    check("t4a m0_ack", a.m0_ack_o, 1);
    check("t4a m0_rdata kept", a.m0_rdata_o, 32'h0000B0B0);
    a.c_valid_i = 0; a.m0_req_i = 0;
    tick();

    // reset while m1 is BUSY
    a.m1_req_i = 1; a.m1_we_i = 0; a.m1_addr_i = 32'h80;
    tick();
    check("t4 c1 c_read", a.c_read_o, 1);
    tick();
    rst = 1'b1; a.m1_req_i = 0;
    tick();
    check("t4 rst c_read", a.c_read_o, 0);
    check("t4 rst c_addr", a.c_addr_o, 0);
    check("t4 rst m0_rdata", a.m0_rdata_o, 0);
    check("t4 rst m1_rdata", a.m1_rdata_o, 0);
    check("t4 rst m1_ack", a.m1_ack_o, 0);
    rst = 1'b0;

    // stray c_valid in IDLE is ignored
    for (int c = 0; c < 5; c++) begin
      a.c_valid_i = (c == 1); a.c_data_i = 32'hFFFFFFFF;
      tick();
      check($sformatf("t5 c%0d acks", c), {a.m0_ack_o, a.m1_ack_o, a.m0_err_o, a.m1_err_o}, 0);
      check($sformatf("t5 c%0d m1_rdata", c), a.m1_rdata_o, 0);
    end
    a.c_valid_i = 0;

    // after reset a simultaneous pair serves m0 first
    a.m0_req_i = 1; a.m0_we_i = 0; a.m0_addr_i = 32'h300;
    a.m1_req_i = 1; a.m1_we_i = 1; a.m1_addr_i = 32'h400; a.m1_wdata_i = 32'h401;
    tick();
    check("t4b c1 c_read", a.c_read_o, 1);
    check("t4b c1 c_write", a.c_write_o, 0);
    check("t4b c1 c_addr", a.c_addr_o, 32'h300);
    a.c_valid_i = 1; a.c_data_i = 32'h77;
    tick();
    check("t4b c2 m0_ack", a.m0_ack_o, 1);
    check("t4b c2 m1_ack", a.m1_ack_o, 0);
    check("t4b c2 m0_rdata", a.m0_rdata_o, 32'h77);
    a.c_valid_i = 0; a.m0_req_i = 0; a.m1_req_i = 0;
    tick();

    // TIMEOUT=0: silent for 1000 cycles, valid at cycle 1000
    b.m0_req_i = 1; b.m0_we_i = 0; b.m0_addr_i = 32'h900;
    for (int c = 1; c < 1000; c++) begin
      tick();
      check($sformatf("t6 c%0d c_read", c), b.c_read_o, 1);
      check($sformatf("t6 c%0d m0_err", c), b.m0_err_o, 0);
    end
    tick();
    check("t6 c1000 c_read", b.c_read_o, 1);
    b.c_valid_i = 1; b.c_data_i = 32'h1000;
    tick();
    check("t6 c1001 m0_ack", b.m0_ack_o, 1);
    check("t6 c1001 m0_err", b.m0_err_o, 0);
    check("t6 c1001 c_read", b.c_read_o, 0);
    check("t6 c1001 m0_rdata", b.m0_rdata_o, 32'h1000);
    b.c_valid_i = 0; b.m0_req_i = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
